// File: rtl/game_pkg.sv
// Shared definitions for the arcade board: sequencer state encoding and
// playfield geometry used by the update managers.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    COLLIDE   = 3'd2,
    MOVE      = 3'd3,
    VIEW      = 3'd4,
    BLOCKS    = 3'd5,
    RENDER    = 3'd6,
    OVER      = 3'd7
  } state_t;

  localparam int SCR_W     = 400;
  localparam int SCR_H     = 700;
  localparam int BLK_W     = 80;
  localparam int BLK_H     = 15;
  localparam int MAX_JMP_H = 200;

  function automatic logic block_fits(input logic [31:0] x);
    return x <= 32'(SCR_W - BLK_W);
  endfunction

  function automatic logic reachable(input logic [31:0] dy);
    return dy <= 32'(MAX_JMP_H - BLK_H);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Physics tick prescaler: counts clk cycles, holds while paused in WAIT_TICK,
// keeps one pending tick and flags any tick that had to be dropped.
module tick_divider #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hold,
  input  logic clear,
  input  logic take,
  output logic tick_pending,
  output logic overrun
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          tick;

  assign tick = run && !hold && (count == LAST);

  // A tick landing on the same cycle the pending one is consumed is kept, not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      count        <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (run && !hold) count <= (count == LAST) ? '0 : count + 1'b1;
      tick_pending <= (tick_pending && !take) || tick;
      if (tick && tick_pending && !take) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Frame controller: on each physics tick walks the update units through a
// req/done handshake, with per-stage timeout and a fall check after VIEW.
module game_sequencer
  import game_pkg::state_t, game_pkg::IDLE, game_pkg::WAIT_TICK, game_pkg::COLLIDE,
         game_pkg::MOVE, game_pkg::VIEW, game_pkg::BLOCKS, game_pkg::RENDER, game_pkg::OVER;
#(
  parameter int TICK_DIV      = 100,
  parameter int STAGE_TIMEOUT = 255,
  parameter int SCR_H         = game_pkg::SCR_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  output logic        coll_req,
  input  logic        coll_done,
  output logic        doodle_req,
  input  logic        doodle_done,
  output logic        view_req,
  input  logic        view_done,
  output logic        block_req,
  input  logic        block_done,
  output logic        render_req,
  input  logic        render_done,
  input  logic [31:0] doodle_y,
  input  logic [31:0] min_y,
  output logic [2:0]  state,
  output logic [15:0] frame_count,
  output logic        game_over,
  output logic        overrun,
  output logic        timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(STAGE_TIMEOUT - 1);

  state_t      cur, nxt;
  logic [15:0] stage_cnt;
  logic        stage_active, stage_done, stage_end, stage_to;
  logic        start_go, take, fell, tick_pending;
  logic [32:0] y_ext, lo_ext, hi_ext;

  assign state        = cur;
  assign stage_active = (cur == COLLIDE) || (cur == MOVE) || (cur == VIEW) ||
                        (cur == BLOCKS) || (cur == RENDER);
  assign start_go     = start && ((cur == IDLE) || (cur == OVER));
  assign take         = (cur == WAIT_TICK) && tick_pending && !pause;
  assign stage_end    = stage_active && (stage_done || (stage_cnt == TO_LAST));
  assign stage_to     = stage_active && !stage_done && (stage_cnt == TO_LAST);

  // 33-bit compare so a view bottom near the top of the range cannot wrap the upper limit.
  assign y_ext  = {1'b0, doodle_y};
  assign lo_ext = {1'b0, min_y};
  assign hi_ext = lo_ext + 33'(SCR_H);
  assign fell   = (y_ext < lo_ext) || (y_ext > hi_ext);

  always_comb begin
    stage_done = 1'b0;
    case (cur)
      COLLIDE: stage_done = coll_done;
      MOVE:    stage_done = doodle_done;
      VIEW:    stage_done = view_done;
      BLOCKS:  stage_done = block_done;
      RENDER:  stage_done = render_done;
      default: stage_done = 1'b0;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE, OVER: if (start)     nxt = WAIT_TICK;
      WAIT_TICK:  if (take)      nxt = COLLIDE;
      COLLIDE:    if (stage_end) nxt = MOVE;
      MOVE:       if (stage_end) nxt = VIEW;
      VIEW:       if (stage_end) nxt = fell ? OVER : BLOCKS;
      BLOCKS:     if (stage_end) nxt = RENDER;
      RENDER:     if (stage_end) nxt = WAIT_TICK;
      default:                   nxt = IDLE;
    endcase
  end

  // Request lines are registered from the next state so each one is high exactly while its stage is current.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= IDLE;
      stage_cnt   <= '0;
      frame_count <= '0;
      timeout_err <= 1'b0;
      game_over   <= 1'b0;
      coll_req    <= 1'b0;
      doodle_req  <= 1'b0;
      view_req    <= 1'b0;
      block_req   <= 1'b0;
      render_req  <= 1'b0;
    end else begin
      cur        <= nxt;
      coll_req   <= (nxt == COLLIDE);
      doodle_req <= (nxt == MOVE);
      view_req   <= (nxt == VIEW);
      block_req  <= (nxt == BLOCKS);
      render_req <= (nxt == RENDER);
      game_over  <= (nxt == OVER);

      if (nxt != cur)        stage_cnt <= '0;
      else if (stage_active) stage_cnt <= stage_cnt + 16'd1;

      if (start_go) begin
        frame_count <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (stage_to) timeout_err <= 1'b1;
        if ((cur == RENDER) && stage_end) frame_count <= frame_count + 16'd1;
      end
    end
  end

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .run         ((cur != IDLE) && (cur != OVER)),
    .hold        (pause && (cur == WAIT_TICK)),
    .clear       (start_go),
    .take        (take),
    .tick_pending(tick_pending),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: fall-check vector table plus hand-written
// sequences for frame timing, timeout, overrun, pause and async reset.
module tb_game_sequencer;

  logic        clk, reset, start, pause;
  logic        coll_req, doodle_req, view_req, block_req, render_req;
  logic        coll_done, doodle_done, view_done, block_done, render_done;
  logic [31:0] doodle_y, min_y;
  logic [2:0]  state;
  logic [15:0] frame_count;
  logic        game_over, overrun, timeout_err;

  int tests = 0;
  int failed = 0;
  int delay = 1;
  logic withhold_render = 1'b0;
  int cyc = 0;
  int multi_req = 0;
  int coll_prev = 0, coll_last = 0;
  logic block_seen = 1'b0, render_seen = 1'b0;
  int order_log[$];

  typedef struct {
    logic [31:0] y;
    logic [31:0] lo;
    logic        fell;
  } fall_vec_t;

  fall_vec_t vecs[8];

  game_sequencer #(
    .TICK_DIV(10),
    .STAGE_TIMEOUT(255),
    .SCR_H(700)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .coll_req(coll_req), .coll_done(coll_done),
    .doodle_req(doodle_req), .doodle_done(doodle_done),
    .view_req(view_req), .view_done(view_done),
    .block_req(block_req), .block_done(block_done),
    .render_req(render_req), .render_done(render_done),
    .doodle_y(doodle_y), .min_y(min_y),
    .state(state), .frame_count(frame_count), .game_over(game_over),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stage responder: answers each req after 'delay' cycles of it being high.
  initial begin
    int cnt[5];
    logic [4:0] r;
    logic [4:0] d;
    {coll_done, doodle_done, view_done, block_done, render_done} = '0;
    forever begin
      @(negedge clk);
      r = {render_req, block_req, view_req, doodle_req, coll_req};
      for (int i = 0; i < 5; i++) begin
        if (r[i]) cnt[i]++;
        else cnt[i] = 0;
        d[i] = r[i] && (cnt[i] >= delay) && !((i == 4) && withhold_render);
      end
      {render_done, block_done, view_done, doodle_done, coll_done} = d;
    end
  end

  initial begin
    logic [4:0] r;
    logic [4:0] r_prev;
    r_prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      r = {render_req, block_req, view_req, doodle_req, coll_req};
      if ($countones(r) > 1) multi_req++;
      for (int i = 0; i < 5; i++)
        if (r[i] && !r_prev[i]) order_log.push_back(i);
      if (r[0] && !r_prev[0]) begin
        coll_prev = coll_last;
        coll_last = cyc;
      end
      if (block_req) block_seen = 1'b1;
      if (render_req) render_seen = 1'b1;
      r_prev = r;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(state), 32'(target));
  endtask

  task automatic applyReset();
    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [15:0] prev;
    logic [19:0] ord;

    vecs[0] = '{32'd300, 32'd0, 1'b0};
    vecs[1] = '{32'd50, 32'd100, 1'b1};
    vecs[2] = '{32'd100, 32'd100, 1'b0};
    vecs[3] = '{32'd800, 32'd100, 1'b0};
    vecs[4] = '{32'd801, 32'd100, 1'b1};
    vecs[5] = '{32'hFFFF_FFF0, 32'hFFFF_FF00, 1'b0};
    vecs[6] = '{32'd99, 32'd100, 1'b1};
    vecs[7] = '{32'd0, 32'd0, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    doodle_y = 32'd300;
    min_y = 32'd0;

    // Reset state and first frame timing
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({state, frame_count, game_over, overrun, timeout_err,
                     coll_req, doodle_req, view_req, block_req, render_req}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", 32'(state), 32'd0);
    order_log.delete();
    applyStimulus();
    checkOutput("start_to_wait", 32'(state), 32'd1);
    n = 0;
    while (frame_count != 16'd1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_frame_count", 32'(frame_count), 32'd1);
    ord = 20'hFFFFF;
    if (order_log.size() >= 5)
      ord = {4'(order_log[0]), 4'(order_log[1]), 4'(order_log[2]), 4'(order_log[3]), 4'(order_log[4])};
    checkOutput("req_order", 32'(ord), 32'h01234);
    waitState(3'd2, 30, "second_collide");
    checkOutput("tick_period", 32'(coll_last - coll_prev), 32'd10);
    checkOutput("no_overrun_fast", 32'(overrun), 32'd0);

    // Fall-check table
    foreach (vecs[i]) begin
      waitState(3'd1, 40, "vec_wait");
      doodle_y = vecs[i].y;
      min_y = vecs[i].lo;
      prev = frame_count;
      block_seen = 1'b0;
      render_seen = 1'b0;
      waitState(3'd2, 30, "vec_collide");
      n = 0;
      while (!(state == 3'd1 || state == 3'd7) && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("fall_state", 32'(state), vecs[i].fell ? 32'd7 : 32'd1);
      checkOutput("fall_frames", 32'(frame_count), vecs[i].fell ? 32'(prev) : 32'(prev + 16'd1));
      if (vecs[i].fell) begin
        checkOutput("over_flag", 32'(game_over), 32'd1);
        checkOutput("over_skips_stages", 32'({block_seen, render_seen}), 32'd0);
        applyStimulus();
        checkOutput("restart_state", 32'(state), 32'd1);
        checkOutput("restart_frames", 32'(frame_count), 32'd0);
        checkOutput("restart_over_flag", 32'(game_over), 32'd0);
      end
    end
    checkOutput("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Render timeout, then immediate next frame from the pending tick
    withhold_render = 1'b1;
    waitState(3'd6, 40, "reach_render");
    prev = frame_count;
    n = 0;
    while (render_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    checkOutput("render_req_cycles", 32'(n), 32'd255);
    checkOutput("timeout_to_wait", 32'(state), 32'd1);
    checkOutput("timeout_err", 32'(timeout_err), 32'd1);
    checkOutput("timeout_frame_inc", 32'(frame_count), 32'(prev + 16'd1));
    checkOutput("timeout_overrun", 32'(overrun), 32'd1);
    withhold_render = 1'b0;
    @(negedge clk);
    checkOutput("pending_leaves_wait", 32'(state), 32'd2);

    // Slow stages overrun the tick; frames run back-to-back
    applyReset();
    checkOutput("overrun_cleared", 32'({overrun, timeout_err}), 32'd0);
    doodle_y = 32'd300;
    min_y = 32'd0;
    delay = 5;
    applyStimulus();
    n = 0;
    while (frame_count != 16'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("slow_frames", 32'(frame_count), 32'd2);
    checkOutput("slow_overrun", 32'(overrun), 32'd1);
    checkOutput("slow_in_wait", 32'(state), 32'd1);
    @(negedge clk);
    checkOutput("back_to_back", 32'(state), 32'd2);
    checkOutput("slow_no_timeout", 32'(timeout_err), 32'd0);

    // Pause mid-frame: frame completes, tick count holds in WAIT_TICK
    applyReset();
    delay = 1;
    applyStimulus();
    waitState(3'd3, 30, "reach_move");
    pause = 1'b1;
    waitState(3'd1, 20, "pause_frame_done");
    checkOutput("pause_frame_count", 32'(frame_count), 32'd1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (state != 3'd1) bad++;
    end
    checkOutput("pause_hold", 32'(bad), 32'd0);
    pause = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != 3'd2 && n < 40);
    checkOutput("resume_latency", 32'(n), 32'd5);
    checkOutput("pause_no_overrun", 32'(overrun), 32'd0);

    // Asynchronous reset during BLOCKS
    waitState(3'd5, 30, "reach_blocks");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_block_req", 32'(block_req), 32'd0);
    checkOutput("async_state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    checkOutput("single_req", 32'(multi_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
